// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared ALU definitions: sequencer state encoding, byte width
//               and the operand-length normalisation helper.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // A requested length of 0, or one beyond the operand width, selects the
    // full operand width.
    function automatic int norm_len(input int len, input int nbytes);
        if (len == 0 || len > nbytes) begin
            return nbytes;
        end
        return len;
    endfunction

endpackage
`default_nettype wire

// File: rtl/add8.sv
`default_nettype none
// ============================================================================
// Module      : add8
// Description : 8-bit ripple-carry adder.
//   sum  (out, 8) : a + b + cin, low 8 bits
//   cout (out, 1) : carry out of bit 7
//   a, b (in, 8)  : addends
//   cin  (in, 1)  : carry in
// Revision    : 1.0 - initial release
// ============================================================================
module add8 (
    output logic [7:0] sum,
    output logic       cout,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin
);

    logic [8:0] w_c;

    assign w_c[0] = cin;

    for (genvar i = 0; i < 8; i++) begin : g_bit
        assign sum[i]   = a[i] ^ b[i] ^ w_c[i];
        assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
    end

    assign cout = w_c[8];

endmodule
`default_nettype wire

// File: rtl/add_seq.sv
`default_nettype none
// ============================================================================
// Module      : add_seq
// Description : Multi-precision add/subtract sequencer. Operands of up to
//               8*NBYTES bits are pushed through one shared 8-bit adder,
//               least significant byte first, carrying between bytes.
//   clk    (in)            : clock
//   rst    (in)            : synchronous active-high reset
//   start  (in)            : operation request (accepted in IDLE/DONE)
//   sub    (in)            : 0 = A+B, 1 = A-B
//   len    (in, LW)        : active bytes, 0 or >NBYTES means NBYTES
//   op_a   (in, 8*NBYTES)  : operand A
//   op_b   (in, 8*NBYTES)  : operand B
//   busy   (out)           : high while running
//   done   (out)           : one-cycle completion pulse
//   result (out, 8*NBYTES) : sum/difference, inactive bytes zero
//   cout   (out)           : carry out of the top active byte
//   ovf    (out)           : signed overflow at the top active bit
//   zero   (out)           : all active result bytes zero
// Revision    : 1.0 - initial release
// ============================================================================
module add_seq
    import alu_pkg::*;
#(
    parameter int NBYTES = 4,
    parameter int LW     = $clog2(NBYTES + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     sub,
    input  logic [LW-1:0]            len,
    input  logic [BYTE_W*NBYTES-1:0] op_a,
    input  logic [BYTE_W*NBYTES-1:0] op_b,
    output logic                     busy,
    output logic                     done,
    output logic [BYTE_W*NBYTES-1:0] result,
    output logic                     cout,
    output logic                     ovf,
    output logic                     zero
);

    localparam int W = BYTE_W * NBYTES;

    state_t          r_state;
    state_t          w_next;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;          // already inverted for subtract
    logic [W-1:0]    r_result;
    logic [LW-1:0]   r_len;
    logic [LW-1:0]   r_idx;
    logic            r_carry;
    logic            r_nz;         // some byte written so far was non-zero
    logic            r_cout;
    logic            r_ovf;
    logic            r_zero;

    logic [BYTE_W-1:0] w_a_byte;
    logic [BYTE_W-1:0] w_b_byte;
    logic [BYTE_W-1:0] w_sum;
    logic              w_co;
    logic              w_last;
    logic              w_accept;

    // Byte select for the shared adder.
    always_comb begin
        w_a_byte = '0;
        w_b_byte = '0;
        for (int i = 0; i < NBYTES; i++) begin
            if (r_idx == LW'(i)) begin
                w_a_byte = r_a[i*BYTE_W +: BYTE_W];
                w_b_byte = r_b[i*BYTE_W +: BYTE_W];
            end
        end
    end

    add8 u_add8 (
        .sum  (w_sum),
        .cout (w_co),
        .a    (w_a_byte),
        .b    (w_b_byte),
        .cin  (r_carry)
    );

    assign w_last   = (r_idx == r_len - LW'(1));
    assign w_accept = start && (r_state == IDLE || r_state == DONE);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and status outputs.
    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) w_next = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (w_last) w_next = DONE;
            end
            DONE: begin
                done   = 1'b1;
                w_next = start ? RUN : IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Operand capture and byte-serial datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_len    <= '0;
            r_idx    <= '0;
            r_carry  <= 1'b0;
            r_nz     <= 1'b0;
            r_result <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
            r_zero   <= 1'b0;
        end else if (w_accept) begin
            r_a      <= op_a;
            r_b      <= sub ? ~op_b : op_b;
            r_len    <= LW'(norm_len(int'(len), NBYTES));
            r_idx    <= '0;
            // Carry-in of 1 completes the two's complement of ~B.
            r_carry  <= sub;
            r_nz     <= 1'b0;
            r_result <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
            r_zero   <= 1'b0;
        end else if (r_state == RUN) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (r_idx == LW'(i)) begin
                    r_result[i*BYTE_W +: BYTE_W] <= w_sum;
                end
            end
            r_carry <= w_co;
            r_idx   <= r_idx + LW'(1);
            r_nz    <= r_nz | (|w_sum);
            if (w_last) begin
                r_cout <= w_co;
                r_ovf  <= (w_a_byte[BYTE_W-1] == w_b_byte[BYTE_W-1]) &&
                          (w_sum[BYTE_W-1] != w_a_byte[BYTE_W-1]);
                r_zero <= !(r_nz || (|w_sum));
            end
        end
    end

    assign result = r_result;
    assign cout   = r_cout;
    assign ovf    = r_ovf;
    assign zero   = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_add_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_add_seq
// Description : Self-checking bench for add_seq (NBYTES=4) against an
//               arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_add_seq;

    localparam int NB = 4;
    localparam int LW = $clog2(NB + 1);
    localparam int W  = 8 * NB;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          sub;
    logic [LW-1:0] len;
    logic [W-1:0]  op_a;
    logic [W-1:0]  op_b;
    logic          busy;
    logic          done;
    logic [W-1:0]  result;
    logic          cout;
    logic          ovf;
    logic          zero;

    int errors = 0;
    int checks = 0;

    add_seq #(.NBYTES(NB)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .sub    (sub),
        .len    (len),
        .op_a   (op_a),
        .op_b   (op_b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .ovf    (ovf),
        .zero   (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs one operation starting from IDLE or DONE and checks everything
    // against the arithmetic model. Returns during the DONE cycle.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sb, input int ln, input string tag);
        int          l;
        int          n;
        int          bcnt;
        longint unsigned mask;
        longint unsigned ea;
        longint unsigned eb;
        longint unsigned full;
        longint      sa;
        longint      sbv;
        longint      exact;
        longint      lim;
        logic [63:0] exp_res;
        logic        exp_co;
        logic        exp_ovf;

        op_a  = a;
        op_b  = b;
        sub   = sb;
        len   = LW'(ln);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        // Scramble the inputs: the operation must use the captured values.
        op_a  = $urandom;
        op_b  = $urandom;
        sub   = 1'($urandom);
        len   = LW'($urandom);

        l     = (ln == 0 || ln > NB) ? NB : ln;
        mask  = (64'd1 << (8 * l)) - 64'd1;
        ea    = 64'(a) & mask;
        eb    = 64'(b) & mask;
        full  = sb ? (ea + ((~eb) & mask) + 64'd1) : (ea + eb);
        exp_res = full & mask;
        exp_co  = full[8 * l];
        // Signed overflow: true result lies outside the l-byte signed range.
        sa    = ea[8*l-1]  ? longint'(ea) - longint'(64'd1 << (8 * l)) : longint'(ea);
        sbv   = eb[8*l-1]  ? longint'(eb) - longint'(64'd1 << (8 * l)) : longint'(eb);
        exact = sb ? sa - sbv : sa + sbv;
        lim   = longint'(64'd1 << (8 * l - 1));
        exp_ovf = (exact >= lim) || (exact < -lim);

        n    = 0;
        bcnt = 0;
        while (!done && n < 20) begin
            bcnt += int'(busy);
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_done"},    64'(done),   64'd1);
        check({tag, "_latency"}, 64'(n),      64'(l));
        check({tag, "_busy"},    64'(bcnt),   64'(l));
        check({tag, "_result"},  64'(result), exp_res);
        check({tag, "_cout"},    64'(cout),   64'(exp_co));
        check({tag, "_ovf"},     64'(ovf),    64'(exp_ovf));
        check({tag, "_zero"},    64'(zero),   64'(exp_res == 64'd0));
    endtask

    initial begin
        int ndone;
        int cyc;
        int last;
        int seen;

        rst   = 1'b1;
        start = 1'b0;
        sub   = 1'b0;
        len   = '0;
        op_a  = '0;
        op_b  = '0;
        @(posedge clk); @(posedge clk); #1;
        check("rst_busy",   64'(busy),   64'd0);
        check("rst_done",   64'(done),   64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_flags",  64'({cout, ovf, zero}), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Carry ripples through every byte.
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 4, "add_wrap");
        @(posedge clk); #1;

        // Borrow out of the full width; then outputs must hold.
        run_op(32'h0000_0000, 32'h0000_0001, 1'b1, 4, "sub_borrow");
        @(posedge clk); #1;
        check("hold_done",   64'(done),   64'd0);
        check("hold_result", 64'(result), 64'hFFFF_FFFF);
        check("hold_cout",   64'(cout),   64'd0);

        // Single byte, upper operand bytes ignored.
        run_op(32'hABAB_AB7F, 32'h0000_0001, 1'b0, 1, "len1_ovf");
        @(posedge clk); #1;

        // len=0 means full width.
        run_op(32'h8000_0000, 32'h8000_0000, 1'b0, 0, "len0");
        @(posedge clk); #1;

        // Back-to-back with start held high.
        op_a  = 32'h0000_1234;
        op_b  = 32'h0000_0FCD;
        sub   = 1'b0;
        len   = LW'(2);
        start = 1'b1;
        @(posedge clk); #1;
        ndone = 0;
        cyc   = 0;
        last  = 0;
        while (ndone < 3 && cyc < 30) begin
            @(posedge clk); #1;
            cyc++;
            if (done) begin
                ndone++;
                check("b2b_result", 64'(result), 64'h0000_2201);
                check("b2b_period", 64'(cyc - last), (ndone == 1) ? 64'd2 : 64'd3);
                last = cyc;
                if (ndone == 3) start = 1'b0;
            end
        end
        start = 1'b0;
        check("b2b_count", 64'(ndone), 64'd3);
        @(posedge clk); #1;
        check("b2b_idle", 64'(busy), 64'd0);

        // Reset in the middle of an operation.
        op_a  = 32'h1111_1111;
        op_b  = 32'h2222_2222;
        sub   = 1'b0;
        len   = LW'(4);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy",   64'(busy),   64'd0);
        check("abort_done",   64'(done),   64'd0);
        check("abort_result", 64'(result), 64'd0);
        check("abort_flags",  64'({cout, ovf, zero}), 64'd0);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            seen += int'(done);
        end
        check("abort_nodone", 64'(seen), 64'd0);
        run_op(32'h1111_1111, 32'h2222_2222, 1'b0, 4, "after_abort");

        // Random operations, some back-to-back.
        for (int k = 0; k < 24; k++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ra = $urandom;
            rb = (k % 5 == 0) ? ra : W'($urandom);
            run_op(ra, rb, 1'($urandom), int'($urandom_range(0, 7)), "rand");
            if (k % 2 == 0) begin
                @(posedge clk); #1;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
